// File: rtl/hrs_min_sec_counter_pkg.sv
// hms_pkg: shared constants and helpers for the hours/minutes/seconds counter.
//   clog2_w      - number of bits needed to hold the values 0..v-1
//   SEC_MAX_DEF  - default seconds terminal value
//   MIN_MAX_DEF  - default minutes terminal value
//   HR_MAX_DEF   - default hours terminal value
package hms_pkg;

    localparam int SEC_MAX_DEF = 9;
    localparam int MIN_MAX_DEF = 9;
    localparam int HR_MAX_DEF  = 15;

    function automatic int clog2_w(input int v);
        int r;
        int x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hrs_min_sec_counter_mod_counter.sv
// mod_counter: modulo-(MAX+1) up-counter with enable and terminal-count output.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, clears cnt
//   en   in   advance enable
//   cnt  out  registered count, WIDTH bits
//   tc   out  en & (cnt == MAX); used as the carry into the next field
module mod_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    // Exact-equality compare: a value above MAX (only reachable via X-init or
    // force) keeps incrementing until it wraps at 2^WIDTH.
    assign at_max = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = en & at_max;

endmodule

// File: rtl/hrs_min_sec_counter.sv
// hrs_min_sec_counter: free-running hours/minutes/seconds time base.
// Seconds advance every clock, minutes on each seconds roll-over, hours on
// each minutes roll-over. Terminal values and field widths are parameters.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears all fields
//   min   out  minutes, O bits, registered
//   sec   out  seconds, O bits, registered
//   hrs   out  hours, P bits, registered
//   wrap  out  (only with HMS_WRAP_PULSE_EN) one-cycle pulse in the cycle the
//              fields read 0:0:0 after a full H:M:N roll-over
// Optional feature macro: HMS_WRAP_PULSE_EN
module hrs_min_sec_counter
    import hms_pkg::*;
#(
    parameter int N = SEC_MAX_DEF,
    parameter int M = MIN_MAX_DEF,
    parameter int O = 4,
    parameter int P = 4,
    parameter int H = HR_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    output logic [O-1:0] min,
    output logic [O-1:0] sec,
    output logic [P-1:0] hrs
`ifdef HMS_WRAP_PULSE_EN
    ,
    output logic         wrap
`endif
);

    if (N < 1 || clog2_w(N + 1) > O) begin : g_bad_n
        $error("hrs_min_sec_counter: N must be >= 1 and fit in O bits");
    end
    if (M < 1 || clog2_w(M + 1) > O) begin : g_bad_m
        $error("hrs_min_sec_counter: M must be >= 1 and fit in O bits");
    end
    if (H < 1 || clog2_w(H + 1) > P) begin : g_bad_h
        $error("hrs_min_sec_counter: H must be >= 1 and fit in P bits");
    end

    logic sec_tc;
    logic min_tc;
    logic hr_tc;

    mod_counter #(.WIDTH(O), .MAX(N)) u_sec (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .cnt (sec),
        .tc  (sec_tc)
    );

    mod_counter #(.WIDTH(O), .MAX(M)) u_min (
        .clk (clk),
        .rst (rst),
        .en  (sec_tc),
        .cnt (min),
        .tc  (min_tc)
    );

    mod_counter #(.WIDTH(P), .MAX(H)) u_hrs (
        .clk (clk),
        .rst (rst),
        .en  (min_tc),
        .cnt (hrs),
        .tc  (hr_tc)
    );

`ifdef HMS_WRAP_PULSE_EN
    logic wrap_q;

    // hr_tc marks the edge that takes H:M:N to 0:0:0, so registering it lines
    // the pulse up with the all-zero cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= hr_tc;
        end
    end

    assign wrap = wrap_q;
`else
    logic unused_hr_tc;
    assign unused_hr_tc = hr_tc;
`endif

endmodule

// File: tb/tb_hrs_min_sec_counter.sv
module tb_hrs_min_sec_counter;

    localparam int N = 9;
    localparam int M = 9;
    localparam int H = 15;
    localparam int SEC_PERIOD  = N + 1;
    localparam int MIN_PERIOD  = (N + 1) * (M + 1);
    localparam int FULL_PERIOD = (N + 1) * (M + 1) * (H + 1);

    logic       clk;
    logic       rst;
    logic [3:0] min;
    logic [3:0] sec;
    logic [3:0] hrs;
`ifdef HMS_WRAP_PULSE_EN
    logic       wrap;
`endif

    int checks;
    int errors;
    int t;          // edges since the last reset edge

    hrs_min_sec_counter dut (
        .clk (clk),
        .rst (rst),
        .min (min),
        .sec (sec),
        .hrs (hrs)
`ifdef HMS_WRAP_PULSE_EN
        ,
        .wrap(wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the time is just the number of free edges since reset.
    function automatic logic [11:0] exp_hms(input int tt);
        int s;
        int m;
        int h;
        s = tt % SEC_PERIOD;
        m = (tt / SEC_PERIOD) % (M + 1);
        h = (tt / MIN_PERIOD) % (H + 1);
        return {4'(h), 4'(m), 4'(s)};
    endfunction

    function automatic logic exp_wrap(input int tt);
        return (tt > 0) && (tt % FULL_PERIOD == 0);
    endfunction

    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) t = 0;
        else   t = t + 1;
    endtask

    task automatic test_reset();
        tick(1'b1);
        checks++;
        if ({hrs, min, sec} !== 12'h000) begin
            errors++;
            $display("FAIL reset_zero: got %h:%h:%h expected 0:0:0", hrs, min, sec);
        end
`ifdef HMS_WRAP_PULSE_EN
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b expected 0", wrap);
        end
`endif
        tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h001) begin
            errors++;
            $display("FAIL first_edge: got %h:%h:%h expected 0:0:1", hrs, min, sec);
        end
    endtask

    task automatic test_sec_rollover();
        tick(1'b1);
        repeat (9) tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h009) begin
            errors++;
            $display("FAIL sec_at_9: got %h:%h:%h expected 0:0:9", hrs, min, sec);
        end
        tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h010) begin
            errors++;
            $display("FAIL sec_carry: got %h:%h:%h expected 0:1:0", hrs, min, sec);
        end
    endtask

    task automatic test_min_rollover();
        tick(1'b1);
        repeat (99) tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h099) begin
            errors++;
            $display("FAIL min_at_9_9: got %h:%h:%h expected 0:9:9", hrs, min, sec);
        end
        tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h100) begin
            errors++;
            $display("FAIL min_carry: got %h:%h:%h expected 1:0:0", hrs, min, sec);
        end
    endtask

    task automatic test_full_wrap();
        tick(1'b1);
        repeat (1599) tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'hF99) begin
            errors++;
            $display("FAIL full_before: got %h:%h:%h expected f:9:9", hrs, min, sec);
        end
`ifdef HMS_WRAP_PULSE_EN
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_early: got %b expected 0", wrap);
        end
`endif
        tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h000) begin
            errors++;
            $display("FAIL full_wrap: got %h:%h:%h expected 0:0:0", hrs, min, sec);
        end
`ifdef HMS_WRAP_PULSE_EN
        checks++;
        if (wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse: got %b expected 1", wrap);
        end
        tick(1'b0);
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_width: got %b expected 0", wrap);
        end
`endif
    endtask

    task automatic test_long_run();
        int bad;
        logic [11:0] e;
        bad = 0;
        tick(1'b1);
        for (int i = 0; i < 30 * FULL_PERIOD; i++) begin
            tick(1'b0);
            e = exp_hms(t);
            if (sec > 4'(N) || min > 4'(M) || hrs > 4'(H)) begin
                if (bad < 5) $display("FAIL long_bounds: t=%0d got %h:%h:%h", t, hrs, min, sec);
                bad++;
            end else if ({hrs, min, sec} !== e) begin
                if (bad < 5) $display("FAIL long_model: t=%0d got %h:%h:%h expected %h", t, hrs, min, sec, e);
                bad++;
            end
`ifdef HMS_WRAP_PULSE_EN
            else if (wrap !== exp_wrap(t)) begin
                if (bad < 5) $display("FAIL long_wrap: t=%0d got %b expected %b", t, wrap, exp_wrap(t));
                bad++;
            end
`endif
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL long_run: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if ({hrs, min, sec} !== 12'h000) begin
            errors++;
            $display("FAIL long_end: got %h:%h:%h expected 0:0:0", hrs, min, sec);
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1);
        repeat (345) tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h345) begin
            errors++;
            $display("FAIL mid_reach: got %h:%h:%h expected 3:4:5", hrs, min, sec);
        end
        tick(1'b1);
        checks++;
        if ({hrs, min, sec} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset: got %h:%h:%h expected 0:0:0", hrs, min, sec);
        end
        tick(1'b0);
        checks++;
        if ({hrs, min, sec} !== 12'h001) begin
            errors++;
            $display("FAIL mid_resume: got %h:%h:%h expected 0:0:1", hrs, min, sec);
        end
    endtask

    task automatic test_random_reset();
        logic [11:0] e;
        logic r;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 29) == 0);
            // occasionally run a long stretch so the hours field gets exercised
            if (!r && $urandom_range(0, 49) == 0) begin
                repeat ($urandom_range(50, 400)) tick(1'b0);
            end
            tick(r);
            e = exp_hms(t);
            checks++;
            if ({hrs, min, sec} !== e) begin
                errors++;
                $display("FAIL random: i=%0d rst=%b got %h:%h:%h expected %h", i, r, hrs, min, sec, e);
            end
`ifdef HMS_WRAP_PULSE_EN
            checks++;
            if (wrap !== exp_wrap(t)) begin
                errors++;
                $display("FAIL random_wrap: i=%0d got %b expected %b", i, wrap, exp_wrap(t));
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        t = 0;
        rst = 1'b1;
        test_reset();
        test_sec_rollover();
        test_min_rollover();
        test_full_wrap();
        test_mid_reset();
        test_random_reset();
        test_long_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
